// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Holds opcodes, mux select encodings and the control FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP,
        S_ADDIEX,
        S_ADDIWB
    } state_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter with timeout compare.
// Count is zero on the first cycle of every wait state.
module mc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    input  logic i_ready,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall   = i_wait & ~i_ready;
    assign o_timeout = (TIMEOUT != 0) && w_stall && (r_cnt == LP_LAST);

    // Any cycle that is not a continuing stall leaves the count at zero,
    // so every entry into a wait state starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && !o_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Outputs decode from state, plus mem_ready and zero.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       bus_err
);

    state_t r_state;
    state_t w_next;
    logic   w_wait;
    logic   w_tmo;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wait    (w_wait),
        .i_ready   (mem_ready),
        .o_timeout (w_tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_source  = PCSRC_ALU;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_tmo) begin
                    bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = ~w_tmo;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_tmo) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_en     = zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit select lines of the datapath 4:1 muxes (ALU operand B, PC source), plus all write enables.
- Waits on a memory ready handshake and aborts to fetch on a memory timeout.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ready in a memory state; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- iord  out  1  0 = PC, 1 = ALUOut as memory address.
- mem_read, mem_write, ir_write  out  1 each.
- reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target; 3 is never driven.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset:
  - Only the state register and wait counter are flops; outputs are decoded combinationally from state (plus mem_ready and zero where noted).
  - rst_n low forces state IDLE; all outputs are 0 in IDLE.
  - IDLE -> FETCH on the first clock after reset release.
  - Reset asserted mid-instruction aborts it immediately; no write enable survives.
- States and outputs (any output not listed is 0):
  - IDLE: all outputs 0.
  - FETCH: mem_read=1, alu_src_b=1, alu_op=00, pc_source=0. When mem_ready=1, also ir_write=1 and pc_en=1. Leave on mem_ready to DECODE; otherwise stay.
  - DECODE: alu_src_b=3, alu_op=00. Next state by opcode:
    - 0x23 or 0x2B -> MEMADR
    - 0x00 -> EXEC
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDIEX
    - any other opcode: illegal_op=1 this cycle -> FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=2. Next is MEMRD if opcode 0x23, MEMWR if 0x2B.
  - MEMRD: iord=1, mem_read=1; stay until mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEMWR: iord=1, mem_write=1; stay until mem_ready, then -> FETCH.
  - EXEC: alu_src_a=1, alu_src_b=0, alu_op=10 -> ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_source=1, pc_en=zero -> FETCH.
  - JUMP: pc_source=2, pc_en=1 -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=00 -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Opcode sampling: opcode is read in DECODE and MEMADR only; IR is stable there.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - If TIMEOUT != 0 and the count reaches TIMEOUT-1 with mem_ready=0: bus_err=1 that cycle, the state's write enables are suppressed, next state FETCH.
  - mem_ready=1 in the same cycle as the timeout: mem_ready wins and there is no bus_err.
- Invariants:
  - mem_read and mem_write are never both 1.
  - pc_source is never 3.
  - At most one of ir_write and reg_write is asserted.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - alu_src_b encodings, pc_source encodings, alu_op encodings.
  - State enum, so the datapath bench can decode it.
- Sub-module mc_wait_timer: wait counter plus timeout compare, parameterised by TIMEOUT and CNT_W.
- The FSM and output decode stay in mips_mc_control.

Test Plan:
- Reset/IDLE: hold rst_n low 3 cycles, release with mem_ready=1 -> all outputs 0 in IDLE; FETCH on the next clock with mem_read=1, ir_write=1, pc_en=1, alu_src_b=1.
- lw stall: opcode 0x23, mem_ready low 2 cycles in MEMRD -> state sequence FETCH, DECODE, MEMADR, MEMRD x3, MEMWB; reg_write=1 with mem_to_reg=1 exactly once.
- R-type and addi: opcode 0x00 -> alu_op=10 and alu_src_b=0 in EXEC, reg_dst=1 in ALUWB. Opcode 0x08 -> alu_src_b=2 in ADDIEX, reg_dst=0 in ADDIWB. Both take 4 cycles.
- beq and j: opcode 0x04 with zero=1 -> pc_en=1, pc_source=1 in BRANCH; with zero=0 -> pc_en=0. Opcode 0x02 -> pc_en=1, pc_source=2. Both take 3 cycles.
- Timeout: TIMEOUT=4, sw (0x2B) with mem_ready held 0 -> bus_err pulses in the 4th MEMWR cycle, then FETCH. Repeat with mem_ready=1 in that same cycle -> no bus_err.
- Illegal opcode and reset mid-op: opcode 0x3F -> illegal_op pulse in DECODE, then FETCH. Assert rst_n during MEMWR -> mem_write drops to 0 asynchronously, state IDLE.
